// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the shared-ALU arbiter.
// The master modport is the requester side; slave is the arbiter side.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_op;
  logic [7:0]  req0_x;
  logic [7:0]  req0_y;
  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_op;
  logic [7:0]  req1_x;
  logic [7:0]  req1_y;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [15:0] rsp_z;

  modport master (
    output req0_valid, req0_op, req0_x, req0_y,
    output req1_valid, req1_op, req1_x, req1_y,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_z
  );

  modport slave (
    input  req0_valid, req0_op, req0_x, req0_y,
    input  req1_valid, req1_op, req1_x, req1_y,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_z
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Define ALU_ARBITER_CNT_EN to add the ops_done completed-handshake counter.
module alu_arbiter #(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus,
  output logic [1:0]   alu_m,
  output logic [7:0]   alu_x,
  output logic [7:0]   alu_y,
  input  logic [15:0]  alu_z
`ifdef ALU_ARBITER_CNT_EN
  ,
  output logic [15:0]  ops_done
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t      state_reg, state_next;
  logic        ptr_reg, ptr_next;
  logic        owner_reg, owner_next;
  logic [1:0]  op_reg, op_next;
  logic [7:0]  x_reg, x_next;
  logic [7:0]  y_reg, y_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] z_reg, z_next;

  logic grant;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid;

  assign bus.req0_ready = req0_ready;
  assign bus.req1_ready = req1_ready;
  assign bus.rsp0_valid = rsp0_valid;
  assign bus.rsp1_valid = rsp1_valid;
  assign bus.rsp_z      = z_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      owner_reg <= 1'b0;
      op_reg    <= 2'b00;
      x_reg     <= 8'h00;
      y_reg     <= 8'h00;
      cnt_reg   <= 4'd0;
      z_reg     <= 16'h0000;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      op_reg    <= op_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      cnt_reg   <= cnt_next;
      z_reg     <= z_next;
    end
  end

  // The pointer only matters on a tie; a lone valid requester always wins.
  assign grant = (bus.req0_valid && bus.req1_valid) ? ptr_reg : bus.req1_valid;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    op_next    = op_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    cnt_next   = cnt_reg;
    z_next     = z_reg;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    alu_m      = 2'b00;
    alu_x      = 8'h00;
    alu_y      = 8'h00;
    case (state_reg)
      IDLE: begin
        // Ready is combinational, so it must be held off while reset is asserted.
        if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
          req0_ready = !grant;
          req1_ready = grant;
          owner_next = grant;
          op_next    = grant ? bus.req1_op : bus.req0_op;
          x_next     = grant ? bus.req1_x  : bus.req0_x;
          y_next     = grant ? bus.req1_y  : bus.req0_y;
          cnt_next   = (op_next == 2'b10) ? MUL_LOAD : 4'd0;
          state_next = EXEC;
        end
      end
      EXEC: begin
        alu_m = op_reg;
        alu_x = x_reg;
        alu_y = y_reg;
        if (cnt_reg == 4'd0) begin
          z_next     = (op_reg == 2'b11) ? 16'h0000 : alu_z;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        rsp0_valid = !owner_reg;
        rsp1_valid = owner_reg;
        if (owner_reg ? bus.rsp1_ready : bus.rsp0_ready) begin
          ptr_next   = !owner_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ALU_ARBITER_CNT_EN
  logic        handshake;
  logic [15:0] ops_done_reg;

  assign handshake = (state_reg == RESP) && (owner_reg ? bus.rsp1_ready : bus.rsp0_ready);
  assign ops_done  = ops_done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_done_reg <= 16'h0000;
    end else if (handshake) begin
      ops_done_reg <= ops_done_reg + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus round-robin and reset sequences.
module tb_alu_arbiter;
  localparam int MUL_C = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  alu_m;
  logic [7:0]  alu_x, alu_y;
  logic [15:0] alu_z;
`ifdef ALU_ARBITER_CNT_EN
  logic [15:0] ops_done;
  int          exp_ops = 0;
`endif

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_arbiter_if bus();

  alu_arbiter #(.MUL_CYCLES(MUL_C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .alu_m (alu_m),
    .alu_x (alu_x),
    .alu_y (alu_y),
    .alu_z (alu_z)
`ifdef ALU_ARBITER_CNT_EN
    ,
    .ops_done (ops_done)
`endif
  );

  // Reference arithmetic unit; op 11 returns junk that the arbiter must discard.
  always_comb begin
    case (alu_m)
      2'b00:   alu_z = {7'd0, ({1'b0, alu_x} + {1'b0, alu_y})};
      2'b01:   alu_z = {7'd0, ({1'b0, alu_x} - {1'b0, alu_y})};
      2'b10:   alu_z = 16'(alu_x) * 16'(alu_y);
      default: alu_z = 16'hDEAD;
    endcase
  end

  typedef struct {
    bit          who;
    logic [1:0]  op;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] z;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input bit who, input bit v, input logic [1:0] op,
                         input logic [7:0] x, input logic [7:0] y);
    if (!who) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_x = x; bus.req0_y = y;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_x = x; bus.req1_y = y;
    end
  endtask

  function automatic logic get_ready(input bit who);
    return who ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic get_rsp(input bit who);
    return who ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction

  task automatic wait_ready(input bit who, input string name);
    int n = 0;
    while (!get_ready(who) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(get_ready(who)), 32'd1);
  endtask

  // Waits from just after the accept edge until rsp_valid; returns cycles since accept.
  task automatic wait_rsp(input bit who, input logic [1:0] op, input logic [7:0] x,
                          input logic [7:0] y, output int lat, output int mulcyc,
                          output bit busy_ready);
    lat = 0; mulcyc = 0; busy_ready = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (alu_m == 2'b10) mulcyc++;
      busy_ready |= bus.req0_ready | bus.req1_ready;
      if (lat == 1) begin
        check("exec_alu_m", 32'(alu_m), 32'(op));
        check("exec_alu_x", 32'(alu_x), 32'(x));
        check("exec_alu_y", 32'(alu_y), 32'(y));
      end
    end while (!get_rsp(who) && lat < 40);
  endtask

  task automatic handshake(input bit who);
    if (!who) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
`ifdef ALU_ARBITER_CNT_EN
    exp_ops++;
    check("ops_done", 32'(ops_done), 32'(exp_ops));
`endif
    check("rsp_dropped", 32'(get_rsp(who)), 32'd0);
  endtask

  initial begin
    int  lat, mulcyc;
    bit  busy, who, any_rsp;
    logic [15:0] z_hold;

    vecs[0] = '{1'b0, 2'b00, 8'hFF, 8'h01, 16'h0100, 2};
    vecs[1] = '{1'b1, 2'b01, 8'h05, 8'h07, 16'h01FE, 2};
    vecs[2] = '{1'b0, 2'b10, 8'hFF, 8'hFF, 16'hFE01, 1 + MUL_C};
    vecs[3] = '{1'b1, 2'b11, 8'h12, 8'h34, 16'h0000, 2};
    vecs[4] = '{1'b1, 2'b10, 8'h10, 8'h10, 16'h0100, 1 + MUL_C};
    vecs[5] = '{1'b0, 2'b00, 8'h80, 8'h80, 16'h0100, 2};
    vecs[6] = '{1'b0, 2'b01, 8'h00, 8'h01, 16'h01FF, 2};

    set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("rst_rsp_z", 32'(bus.rsp_z), 32'd0);
    check("rst_alu_m", 32'(alu_m), 32'd0);
`ifdef ALU_ARBITER_CNT_EN
    check("rst_ops_done", 32'(ops_done), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      set_req(vecs[i].who, 1'b1, vecs[i].op, vecs[i].x, vecs[i].y);
      #1;
      wait_ready(vecs[i].who, "vec_accept");
      check("vec_other_ready", 32'(get_ready(!vecs[i].who)), 32'd0);
      @(posedge clk);
      #1;
      set_req(vecs[i].who, 1'b0, 2'b00, 8'h00, 8'h00);
      wait_rsp(vecs[i].who, vecs[i].op, vecs[i].x, vecs[i].y, lat, mulcyc, busy);
      check("vec_latency", 32'(lat), 32'(vecs[i].lat));
      check("vec_rsp_z", 32'(bus.rsp_z), 32'(vecs[i].z));
      check("vec_other_rsp", 32'(get_rsp(!vecs[i].who)), 32'd0);
      if (vecs[i].op == 2'b10) check("vec_mul_cycles", 32'(mulcyc), 32'(MUL_C));
      handshake(vecs[i].who);
      @(negedge clk);
    end

    // Round robin from a fresh reset with both requesters permanently valid.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef ALU_ARBITER_CNT_EN
    exp_ops = 0;
`endif
    set_req(1'b0, 1'b1, 2'b00, 8'h01, 8'h01);
    set_req(1'b1, 1'b1, 2'b00, 8'h02, 8'h02);
    #1;
    for (int t = 0; t < 4; t++) begin
      int n = 0;
      while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
        @(negedge clk);
        n++;
      end
      who = bus.req1_ready;
      check("rr_some_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd1);
      check("rr_grant", 32'(who), 32'(t % 2));
      check("rr_one_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      @(posedge clk);
      #1;
      wait_rsp(who, 2'b00, who ? 8'h02 : 8'h01, who ? 8'h02 : 8'h01, lat, mulcyc, busy);
      check("rr_no_ready_busy", 32'(busy), 32'd0);
      check("rr_latency", 32'(lat), 32'd2);
      check("rr_rsp_z", 32'(bus.rsp_z), who ? 32'h4 : 32'h2);
      if (t == 0) begin
        z_hold = bus.rsp_z;
        bus.rsp1_ready = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("hold_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
          check("hold_rsp_z", 32'(bus.rsp_z), 32'(z_hold));
        end
        bus.rsp1_ready = 1'b0;
      end
      handshake(who);
      if (t == 3) begin
        set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
      end
    end

    // Reset in the middle of a multiply.
    @(negedge clk);
    set_req(1'b0, 1'b1, 2'b10, 8'h0F, 8'h0F);
    #1;
    wait_ready(1'b0, "mid_accept");
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    check("mid_alu_m", 32'(alu_m), 32'd2);
    rst_n = 1'b0;
    set_req(1'b1, 1'b1, 2'b00, 8'h03, 8'h04);
    #1;
    check("arst_alu_m", 32'(alu_m), 32'd0);
    check("arst_alu_x", 32'(alu_x), 32'd0);
    check("arst_rsp_z", 32'(bus.rsp_z), 32'd0);
    check("arst_req1_ready", 32'(bus.req1_ready), 32'd0);
    check("arst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
`ifdef ALU_ARBITER_CNT_EN
    check("arst_ops_done", 32'(ops_done), 32'd0);
    exp_ops = 0;
`endif
    @(negedge clk);
    set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    rst_n = 1'b1;
    any_rsp = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_rsp |= bus.rsp0_valid | bus.rsp1_valid;
    end
    check("post_rst_no_rsp", 32'(any_rsp), 32'd0);

    set_req(1'b1, 1'b1, 2'b00, 8'h03, 8'h04);
    #1;
    wait_ready(1'b1, "post_rst_accept");
    @(posedge clk);
    #1;
    set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    wait_rsp(1'b1, 2'b00, 8'h03, 8'h04, lat, mulcyc, busy);
    check("post_rst_latency", 32'(lat), 32'd2);
    check("post_rst_rsp_z", 32'(bus.rsp_z), 32'h7);
    handshake(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter MUL_CYCLES, default 2, SHALL set the number of cycles (1..15) a multiply holds the shared ALU.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0/1 has an operation.
REQ-005 req0_ready / req1_ready  output  1 each  operation accepted this cycle.
REQ-006 req0_op / req1_op  input  2 each  00 add, 01 sub, 10 mul, 11 illegal.
REQ-007 req0_x, req0_y, req1_x, req1_y  input  8 each  operands.
REQ-008 rsp0_valid / rsp1_valid  output  1 each  result available to requester 0/1.
REQ-009 rsp0_ready / rsp1_ready  input  1 each  requester takes result.
REQ-010 rsp_z  output  16  result, shared by both response channels.
REQ-011 alu_m  output  2, alu_x  output  8, alu_y  output  8  drive the shared arithmetic unit.
REQ-012 alu_z  input  16  combinational arithmetic unit result.

Function
REQ-013 FSM states SHALL be IDLE, EXEC and RESP, with one transaction in flight at a time.
REQ-014 IDLE: if any reqN_valid, grant one requester, assert only its reqN_ready combinationally that cycle, latch op/x/y and owner, and go to EXEC.
REQ-015 Arbitration SHALL be round-robin: the priority pointer starts at 0 and moves to the non-owner when a response completes; a lone valid requester always wins.
REQ-016 EXEC: alu_m/alu_x/alu_y SHALL equal the latched values; outside EXEC they SHALL be 0.
REQ-017 Add/sub SHALL occupy EXEC 1 cycle; mul SHALL occupy EXEC MUL_CYCLES cycles via a 4-bit down-counter; alu_z SHALL be captured into rsp_z on the last EXEC cycle.
REQ-018 Op 11 SHALL occupy EXEC 1 cycle and capture rsp_z = 16'h0000 regardless of alu_z.
REQ-019 RESP: the owner's rspN_valid SHALL be high and rsp_z stable until rspN_ready; the handshake cycle returns to IDLE.
REQ-020 Latency: add/sub rspN_valid SHALL rise 2 cycles after the accept cycle; mul SHALL rise 1+MUL_CYCLES cycles after it.
REQ-021 No reqN_ready SHALL assert in EXEC or RESP; a request arriving then SHALL wait (valid held, not dropped).
REQ-022 Both requesters valid in the same IDLE cycle SHALL resolve by the pointer only; the loser is served next.
REQ-023 rspN_ready without rspN_valid SHALL be ignored.

Reset
REQ-024 rst_n low SHALL force IDLE, pointer 0, counter 0, rsp_z 0, all ready/valid and alu_* outputs 0 immediately.
REQ-025 Reset during EXEC or RESP SHALL drop the transaction with no response after release.

Configuration
REQ-026 Macro ALU_ARBITER_CNT_EN defined SHALL add output ops_done [15:0], incremented on every completed response handshake, wrapping FFFF->0000 and reset to 0.
REQ-027 Without ALU_ARBITER_CNT_EN the ops_done port and counter SHALL not exist; all other behaviour is identical.

Verification
REQ-028 Req0 add x=8'hFF y=8'h01, rsp0_ready=1 -> rsp0_valid 2 cycles after accept, rsp_z=16'h0100.
REQ-029 Req1 sub x=8'h05 y=8'h07 -> rsp_z = two's-complement 9-bit result zero-extended (16'h01FE); rsp1_valid only.
REQ-030 MUL_CYCLES=3, req0 mul x=8'hFF y=8'hFF -> alu_m=10 for 3 cycles, rsp_z=16'hFE01 4 cycles after accept.
REQ-031 Both valid continuously for 4 transactions after reset -> grants 0,1,0,1; rsp held while rspN_ready=0 for 5 cycles.
REQ-032 Reset asserted mid-mul -> all outputs 0 asynchronously, no rsp_valid after release, next request served normally.
REQ-033 Op 11 -> rsp_z=16'h0000 after 2 cycles; with ALU_ARBITER_CNT_EN ops_done increments by 1 per handshake.
